// File: rtl/ex_mem.sv
// EX->MEM pipeline register: GPR/HI-LO writeback capture with bubble/hold stall control,
// plus madd/msub intermediate loopback to EX. Optional flush port under EX_MEM_FLUSH_EN.
module ex_mem #(
   parameter int DATA_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 2
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      ex_stall,
   input  logic                      mem_stall,
`ifdef EX_MEM_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic [REG_ADDR_WIDTH-1:0] ex_write_reg_address_input,
   input  logic                      ex_write_reg_enable_input,
   input  logic [DATA_WIDTH-1:0]     ex_write_reg_data_input,
   input  logic [DATA_WIDTH-1:0]     ex_hi_input,
   input  logic [DATA_WIDTH-1:0]     ex_lo_input,
   input  logic                      ex_whilo_input,
   input  logic [2*DATA_WIDTH-1:0]   hilo_temp_input,
   input  logic [CNT_WIDTH-1:0]      cnt_input,
   output logic [REG_ADDR_WIDTH-1:0] mem_write_reg_address_output,
   output logic                      mem_write_reg_enable_output,
   output logic [DATA_WIDTH-1:0]     mem_write_reg_data_output,
   output logic [DATA_WIDTH-1:0]     mem_hi_output,
   output logic [DATA_WIDTH-1:0]     mem_lo_output,
   output logic                      mem_whilo_output,
   output logic [2*DATA_WIDTH-1:0]   hilo_temp_output,
   output logic [CNT_WIDTH-1:0]      cnt_output
);

   typedef enum logic [1:0] {
      ACT_CAPTURE = 2'd0,
      ACT_BUBBLE  = 2'd1,
      ACT_HOLD    = 2'd2
   } act_e;

   act_e                      act;
   logic                      flush_req;

   logic [REG_ADDR_WIDTH-1:0] waddr_q, waddr_d;
   logic                      wen_q, wen_d;
   logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]     hi_q, hi_d;
   logic [DATA_WIDTH-1:0]     lo_q, lo_d;
   logic                      whilo_q, whilo_d;
   logic [2*DATA_WIDTH-1:0]   hilo_temp_q, hilo_temp_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

`ifdef EX_MEM_FLUSH_EN
   assign flush_req = flush;
`else
   assign flush_req = 1'b0;
`endif

   // 01 is never produced by the stall controller; treat it as HOLD so it can't leak a capture.
   always_comb begin
      act = ACT_HOLD;
      case ({ex_stall, mem_stall})
         2'b00:   act = ACT_CAPTURE;
         2'b10:   act = ACT_BUBBLE;
         default: act = ACT_HOLD;
      endcase
   end

   always_comb begin
      waddr_d     = waddr_q;
      wen_d       = wen_q;
      wdata_d     = wdata_q;
      hi_d        = hi_q;
      lo_d        = lo_q;
      whilo_d     = whilo_q;
      hilo_temp_d = hilo_temp_q;
      cnt_d       = cnt_q;
      if (flush_req) begin
         waddr_d     = '0;
         wen_d       = 1'b0;
         wdata_d     = '0;
         hi_d        = '0;
         lo_d        = '0;
         whilo_d     = 1'b0;
         hilo_temp_d = '0;
         cnt_d       = '0;
      end else begin
         case (act)
            ACT_CAPTURE: begin
               waddr_d     = ex_write_reg_address_input;
               wen_d       = ex_write_reg_enable_input;
               wdata_d     = ex_write_reg_data_input;
               hi_d        = ex_hi_input;
               lo_d        = ex_lo_input;
               whilo_d     = ex_whilo_input;
               hilo_temp_d = '0;
               cnt_d       = '0;
            end
            // Bubble into MEM while EX keeps its madd/msub partial state looping back.
            ACT_BUBBLE: begin
               waddr_d     = '0;
               wen_d       = 1'b0;
               wdata_d     = '0;
               hi_d        = '0;
               lo_d        = '0;
               whilo_d     = 1'b0;
               hilo_temp_d = hilo_temp_input;
               cnt_d       = cnt_input;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         waddr_q     <= '0;
         wen_q       <= 1'b0;
         wdata_q     <= '0;
         hi_q        <= '0;
         lo_q        <= '0;
         whilo_q     <= 1'b0;
         hilo_temp_q <= '0;
         cnt_q       <= '0;
      end else begin
         waddr_q     <= waddr_d;
         wen_q       <= wen_d;
         wdata_q     <= wdata_d;
         hi_q        <= hi_d;
         lo_q        <= lo_d;
         whilo_q     <= whilo_d;
         hilo_temp_q <= hilo_temp_d;
         cnt_q       <= cnt_d;
      end
   end

   assign mem_write_reg_address_output = waddr_q;
   assign mem_write_reg_enable_output  = wen_q;
   assign mem_write_reg_data_output    = wdata_q;
   assign mem_hi_output                = hi_q;
   assign mem_lo_output                = lo_q;
   assign mem_whilo_output             = whilo_q;
   assign hilo_temp_output             = hilo_temp_q;
   assign cnt_output                   = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed bench for ex_mem: reset, capture, bubble, hold, illegal 01, cnt transport, flush.
module tb_ex_mem;
   logic        clock = 1'b0;
   logic        reset, ex_stall, mem_stall;
`ifdef EX_MEM_FLUSH_EN
   logic        flush;
`endif
   logic [4:0]  ex_addr;
   logic        ex_en;
   logic [31:0] ex_data, ex_hi, ex_lo;
   logic        ex_whilo;
   logic [63:0] hilo_in;
   logic [1:0]  cnt_in;
   logic [4:0]  m_addr;
   logic        m_en;
   logic [31:0] m_data, m_hi, m_lo;
   logic        m_whilo;
   logic [63:0] hilo_out;
   logic [1:0]  cnt_out;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clock = ~clock;

   ex_mem dut (
      .clock(clock), .reset(reset), .ex_stall(ex_stall), .mem_stall(mem_stall),
`ifdef EX_MEM_FLUSH_EN
      .flush(flush),
`endif
      .ex_write_reg_address_input(ex_addr), .ex_write_reg_enable_input(ex_en),
      .ex_write_reg_data_input(ex_data), .ex_hi_input(ex_hi), .ex_lo_input(ex_lo),
      .ex_whilo_input(ex_whilo), .hilo_temp_input(hilo_in), .cnt_input(cnt_in),
      .mem_write_reg_address_output(m_addr), .mem_write_reg_enable_output(m_en),
      .mem_write_reg_data_output(m_data), .mem_hi_output(m_hi), .mem_lo_output(m_lo),
      .mem_whilo_output(m_whilo), .hilo_temp_output(hilo_out), .cnt_output(cnt_out)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [4:0] a, input logic en, input logic [31:0] d,
                        input logic [31:0] hi, input logic [31:0] lo, input logic wh,
                        input logic [63:0] ht, input logic [1:0] c);
      ex_addr = a; ex_en = en; ex_data = d; ex_hi = hi; ex_lo = lo;
      ex_whilo = wh; hilo_in = ht; cnt_in = c;
   endtask

   task automatic chk_mem(input string tag, input logic [4:0] a, input logic en,
                          input logic [31:0] d, input logic [31:0] hi, input logic [31:0] lo,
                          input logic wh);
      chk({tag, ".addr"},  {59'd0, m_addr}, {59'd0, a});
      chk({tag, ".en"},    {63'd0, m_en},   {63'd0, en});
      chk({tag, ".data"},  {32'd0, m_data}, {32'd0, d});
      chk({tag, ".hi"},    {32'd0, m_hi},   {32'd0, hi});
      chk({tag, ".lo"},    {32'd0, m_lo},   {32'd0, lo});
      chk({tag, ".whilo"}, {63'd0, m_whilo}, {63'd0, wh});
   endtask

   task automatic chk_loop(input string tag, input logic [63:0] ht, input logic [1:0] c);
      chk({tag, ".hilo"}, hilo_out, ht);
      chk({tag, ".cnt"},  {62'd0, cnt_out}, {62'd0, c});
   endtask

   initial begin
`ifdef EX_MEM_FLUSH_EN
      flush = 1'b0;
`endif
      // 1: reset with busy inputs, capture-mode stall
      reset = 1'b1; ex_stall = 1'b0; mem_stall = 1'b0;
      drive(5'd31, 1'b1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1,
            64'hFFFF_0000_FFFF_0000, 2'd3);
      step(); step();
      chk_mem("rst", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk_loop("rst", 64'd0, 2'd0);

      // 2: capture
      reset = 1'b0;
      drive(5'd3, 1'b1, 32'hDEAD_BEEF, 32'h11, 32'h22, 1'b0, 64'hCAFE, 2'd2);
      step();
      chk_mem("cap", 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h11, 32'h22, 1'b0);
      chk_loop("cap", 64'd0, 2'd0);

      // 4: hold for 3 cycles while inputs change
      ex_stall = 1'b1; mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(5'(i + 7), 1'b0, 32'h1000 + i, 32'h77, 32'h88, 1'b1, 64'h1 + i, 2'(i + 1));
         step();
         chk_mem("hold", 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h11, 32'h22, 1'b0);
         chk_loop("hold", 64'd0, 2'd0);
      end

      // 5: illegal 01 behaves as hold
      ex_stall = 1'b0; mem_stall = 1'b1;
      drive(5'd9, 1'b1, 32'h0BAD, 32'h1, 32'h2, 1'b1, 64'h99, 2'd1);
      step();
      chk_mem("s01", 5'd3, 1'b1, 32'hDEAD_BEEF, 32'h11, 32'h22, 1'b0);
      chk_loop("s01", 64'd0, 2'd0);

      // 3: bubble carries madd state back to EX
      ex_stall = 1'b1; mem_stall = 1'b0;
      drive(5'd12, 1'b1, 32'h1234, 32'h5, 32'h6, 1'b1, 64'h1234_5678_9ABC_DEF0, 2'b01);
      step();
      chk_mem("bub", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk_loop("bub", 64'h1234_5678_9ABC_DEF0, 2'b01);

      // hold and 01 after bubble keep the loopback state
      ex_stall = 1'b1; mem_stall = 1'b1;
      drive(5'd13, 1'b1, 32'h9, 32'h9, 32'h9, 1'b1, 64'h5555, 2'd3);
      step();
      chk_loop("bub_hold", 64'h1234_5678_9ABC_DEF0, 2'b01);
      chk_mem("bub_hold", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      ex_stall = 1'b0; mem_stall = 1'b1;
      step();
      chk_loop("bub_s01", 64'h1234_5678_9ABC_DEF0, 2'b01);

      // cnt transport at top of range, then capture clears loopback and takes HI/LO
      ex_stall = 1'b1; mem_stall = 1'b0;
      drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
      step();
      chk_loop("cnt3", 64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
      ex_stall = 1'b0; mem_stall = 1'b0;
      drive(5'd17, 1'b0, 32'h0, 32'h0000_0001, 32'hF00D_0000, 1'b1, 64'h42, 2'd1);
      step();
      chk_mem("cap_hilo", 5'd17, 1'b0, 32'd0, 32'h1, 32'hF00D_0000, 1'b1);
      chk_loop("cap_hilo", 64'd0, 2'd0);

      // reset mid madd discards loopback state even under bubble
      ex_stall = 1'b1; mem_stall = 1'b0;
      drive(5'd4, 1'b1, 32'h4, 32'h4, 32'h4, 1'b1, 64'hABCD, 2'd2);
      step();
      chk_loop("pre_rst", 64'hABCD, 2'd2);
      reset = 1'b1;
      step();
      chk_loop("mid_rst", 64'd0, 2'd0);
      chk_mem("mid_rst", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      reset = 1'b0;

`ifdef EX_MEM_FLUSH_EN
      ex_stall = 1'b1; mem_stall = 1'b0;
      drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'h77, 2'd1);
      step();
      ex_stall = 1'b0; mem_stall = 1'b0;
      drive(5'd21, 1'b1, 32'hBEEF, 32'h3, 32'h4, 1'b1, 64'h0, 2'd0);
      step();
      ex_stall = 1'b1; mem_stall = 1'b0;
      drive(5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 64'h88, 2'd2);
      step();
      chk_loop("pre_fl", 64'h88, 2'd2);
      // 6: flush over hold
      ex_stall = 1'b1; mem_stall = 1'b1; flush = 1'b1;
      step();
      chk_mem("fl_hold", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk_loop("fl_hold", 64'd0, 2'd0);
      flush = 1'b0; ex_stall = 1'b0; mem_stall = 1'b0;
      drive(5'd22, 1'b1, 32'hAB, 32'h1, 32'h2, 1'b1, 64'h0, 2'd0);
      step();
      chk_mem("post_fl", 5'd22, 1'b1, 32'hAB, 32'h1, 32'h2, 1'b1);
      flush = 1'b1; reset = 1'b1;
      step();
      chk_mem("rst_fl", 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0);
      chk_loop("rst_fl", 64'd0, 2'd0);
      flush = 1'b0; reset = 1'b0;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
